// File: rtl/core_pkg.sv
// Shared core definitions: data/register widths, the write-back request
// record and a register-address decode helper.
package core_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  // One-hot register select; x0 never appears in the result.
  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    logic [NUM_REGS-1:0] oh;
    oh    = {{(NUM_REGS-1){1'b0}}, 1'b1} << rd;
    oh[0] = 1'b0;
    return oh;
  endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Small circular FIFO holding accepted load results until the write port
// is free. Depth must be a power of two so the pointers wrap naturally.
module wb_load_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 69
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     head_valid,
  output logic [WIDTH-1:0]         head_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]            count_q, count_d;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count      = count_q;
  assign head_valid = (count_q != {CNT_W{1'b0}});
  assign head_data  = mem_q[rd_ptr_q];

endmodule

// File: rtl/writeback_unit.sv
// Register-file write-side controller: ALU-priority arbitration against a
// queued load path, x0 filtering, and the pending-load scoreboard.
module writeback_unit
  import core_pkg::*;
#(
  parameter int XLEN     = core_pkg::XLEN,
  parameter int LQ_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [XLEN-1:0]       ld_data,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_data,
  output logic [NUM_REGS-1:0]   pending
);

  localparam int CNT_W = $clog2(LQ_DEPTH) + 1;
  localparam int ENT_W = REG_ADDR_W + XLEN;
  localparam logic [CNT_W-1:0] LQ_FULL = CNT_W'(LQ_DEPTH);

  logic [CNT_W-1:0]      lq_count;
  logic                  lq_head_valid;
  logic [ENT_W-1:0]      lq_head;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [XLEN-1:0]       head_data;
  logic                  ld_push;
  logic                  ld_pop;

  logic                  wb_we_q, wb_we_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]       wb_data_q, wb_data_d;
  logic                  wb_from_ld_q, wb_from_ld_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;
  logic [NUM_REGS-1:0]   set_mask, clr_mask;

  assign ld_ready  = (lq_count < LQ_FULL);
  assign ld_push   = ld_valid && ld_ready;
  assign head_rd   = lq_head[XLEN +: REG_ADDR_W];
  assign head_data = lq_head[XLEN-1:0];

  wb_load_fifo #(
    .DEPTH (LQ_DEPTH),
    .WIDTH (ENT_W)
  ) u_load_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (ld_push),
    .push_data  ({ld_rd, ld_data}),
    .pop        (ld_pop),
    .count      (lq_count),
    .head_valid (lq_head_valid),
    .head_data  (lq_head)
  );

  // ALU wins the write port outright; the load head only drains on idle ALU cycles.
  always_comb begin
    ld_pop       = 1'b0;
    wb_we_d      = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    wb_from_ld_d = 1'b0;
    if (alu_valid) begin
      wb_we_d   = (alu_rd != {REG_ADDR_W{1'b0}});
      wb_rd_d   = alu_rd;
      wb_data_d = alu_data;
    end else if (lq_head_valid) begin
      ld_pop       = 1'b1;
      wb_we_d      = (head_rd != {REG_ADDR_W{1'b0}});
      wb_rd_d      = head_rd;
      wb_data_d    = head_data;
      wb_from_ld_d = 1'b1;
    end else begin
      wb_we_d = 1'b0;
    end
  end

  // A pending bit drops once the load's register-file write lands; a fresh issue wins.
  always_comb begin
    set_mask = {NUM_REGS{1'b0}};
    clr_mask = {NUM_REGS{1'b0}};
    if (issue_valid) begin
      set_mask = rd_onehot(issue_rd);
    end else begin
      set_mask = {NUM_REGS{1'b0}};
    end
    if (wb_we_q && wb_from_ld_q) begin
      clr_mask = rd_onehot(wb_rd_q);
    end else begin
      clr_mask = {NUM_REGS{1'b0}};
    end
    pending_d    = (pending_q & ~clr_mask) | set_mask;
    pending_d[0] = 1'b0;
  end

  // Output and scoreboard registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_we_q      <= 1'b0;
      wb_rd_q      <= {REG_ADDR_W{1'b0}};
      wb_data_q    <= {XLEN{1'b0}};
      wb_from_ld_q <= 1'b0;
      pending_q    <= {NUM_REGS{1'b0}};
    end else begin
      wb_we_q      <= wb_we_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      wb_from_ld_q <= wb_from_ld_d;
      pending_q    <= pending_d;
    end
  end

  assign wb_we   = wb_we_q;
  assign wb_rd   = wb_rd_q;
  assign wb_data = wb_data_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed and random stimulus for writeback_unit, checked against a
// queue-based transaction model of the write port and scoreboard.
module tb_writeback_unit;
  import core_pkg::*;

  localparam int LQD = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [63:0] ld_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic [31:0] pending;

  writeback_unit #(.XLEN(64), .LQ_DEPTH(LQD)) dut (
    .clk (clk), .reset (reset),
    .alu_valid (alu_valid), .alu_rd (alu_rd), .alu_data (alu_data),
    .ld_valid (ld_valid), .ld_ready (ld_ready), .ld_rd (ld_rd), .ld_data (ld_data),
    .issue_valid (issue_valid), .issue_rd (issue_rd),
    .wb_we (wb_we), .wb_rd (wb_rd), .wb_data (wb_data), .pending (pending)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: queued loads, current write-port contents, pending set.
  wb_req_t     mq[$];
  logic        m_we      = 1'b0;
  logic [4:0]  m_rd      = 5'd0;
  logic [63:0] m_data    = 64'd0;
  logic        m_known   = 1'b0;
  logic        m_from_ld = 1'b0;
  logic [31:0] m_pend    = 32'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [31:0] np;
    bit          rdy;
    wb_req_t     h;
    rdy = (mq.size() < LQD);
    if (reset) begin
      mq.delete();
      m_we = 1'b0; m_rd = 5'd0; m_data = 64'd0;
      m_known = 1'b1; m_from_ld = 1'b0; m_pend = 32'd0;
    end else begin
      np = m_pend;
      if (m_we && m_from_ld) np[m_rd] = 1'b0;
      if (issue_valid && issue_rd != 5'd0) np[issue_rd] = 1'b1;
      m_pend = np;
      if (alu_valid) begin
        m_we = (alu_rd != 5'd0); m_rd = alu_rd; m_data = alu_data;
        m_known = m_we; m_from_ld = 1'b0;
      end else if (mq.size() > 0) begin
        h = mq.pop_front();
        m_we = (h.rd != 5'd0); m_rd = h.rd; m_data = h.data;
        m_known = m_we; m_from_ld = 1'b1;
      end else begin
        m_we = 1'b0; m_known = 1'b0; m_from_ld = 1'b0;
      end
      if (ld_valid && rdy) mq.push_back('{rd: ld_rd, data: ld_data});
    end
  endtask

  task automatic tick();
    chk("ld_ready", {63'd0, ld_ready}, {63'd0, (mq.size() < LQD)});
    @(posedge clk);
    model_step();
    #1;
    chk("wb_we", {63'd0, wb_we}, {63'd0, m_we});
    if (m_known) begin
      chk("wb_rd", {59'd0, wb_rd}, {59'd0, m_rd});
      chk("wb_data", wb_data, m_data);
    end
    chk("pending", {32'd0, pending}, {32'd0, m_pend});
  endtask

  task automatic idle();
    reset = 1'b0; alu_valid = 1'b0; ld_valid = 1'b0; issue_valid = 1'b0;
  endtask

  initial begin
    idle();
    alu_rd = 5'd0; alu_data = 64'd0; ld_rd = 5'd0; ld_data = 64'd0; issue_rd = 5'd0;
    #1;
    // Reset
    reset = 1'b1; tick(); tick();
    idle(); tick();

    // ALU only, then a dropped x0 write
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234; tick();
    chk("alu_rd5_data", wb_data, 64'h1234);
    alu_rd = 5'd0; alu_data = 64'hFF; tick();
    chk("alu_x0_we", {63'd0, wb_we}, 64'd0);
    idle(); tick();

    // Load with scoreboard
    issue_valid = 1'b1; issue_rd = 5'd7; tick();
    chk("pend7_set", {63'd0, pending[7]}, 64'd1);
    idle(); ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 64'hDEAD_BEEF; tick();
    idle(); tick(); tick();
    chk("ld7_data", wb_data, 64'hDEAD_BEEF);
    tick();
    chk("pend7_clr", {63'd0, pending[7]}, 64'd0);

    // Conflict: ALU busy three cycles while two loads queue up
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_data = 64'(32'hA000 + i);
      ld_valid = (i < 2); ld_rd = 5'(20 + i); ld_data = 64'(32'hB000 + i);
      tick();
    end
    idle(); tick(); tick(); tick();

    // Full and wrap: fill behind a busy ALU, then stream six more
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'h1;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; ld_rd = 5'(8 + i); ld_data = 64'(32'hC000 + i); tick();
    end
    ld_valid = 1'b0; tick();
    alu_valid = 1'b0;
    for (int i = 2; i < 8; i++) begin
      ld_valid = 1'b1; ld_rd = 5'(8 + i); ld_data = 64'(32'hC000 + i);
      for (int k = 0; k < 4; k++) begin
        if (mq.size() < LQD) break;
        tick();
      end
      tick();
    end
    idle(); tick(); tick(); tick();

    // Same-cycle set and clear on x3
    issue_valid = 1'b1; issue_rd = 5'd3; tick();
    idle(); ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 64'h33; tick();
    idle(); tick();
    issue_valid = 1'b1; issue_rd = 5'd3; tick();
    idle(); tick();
    chk("pend3_set_wins", {63'd0, pending[3]}, 64'd1);

    // Reset mid-operation with two loads queued
    issue_valid = 1'b1; issue_rd = 5'd7; tick();
    chk("pend_88", {32'd0, pending}, 64'h88);
    idle(); alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 64'h2;
    ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 64'h3333; tick();
    ld_rd = 5'd7; ld_data = 64'h7777; tick();
    reset = 1'b1; tick();
    chk("rst_pending", {32'd0, pending}, 64'd0);
    chk("rst_ready", {63'd0, ld_ready}, 64'd1);
    idle(); tick(); tick(); tick();

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      reset       = ($urandom_range(63) == 0);
      alu_valid   = ($urandom_range(1) == 1);
      alu_rd      = 5'($urandom_range(31));
      alu_data    = {$urandom, $urandom};
      ld_valid    = ($urandom_range(1) == 1);
      ld_rd       = 5'($urandom_range(31));
      ld_data     = {$urandom, $urandom};
      issue_valid = ($urandom_range(2) == 0);
      issue_rd    = 5'($urandom_range(31));
      tick();
    end
    idle(); tick(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
